// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch/decode front end: widths, reset PC,
// NOP encoding, major opcodes and the fetch FSM state encoding.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave); one outstanding request at a time.
interface instr_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline register backed by a one-entry skid register, so a response
// that lands while decode is stalled is kept rather than dropped.
module if_id_skid_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            stall,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            skid_full
);

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            id_free;

    // IF/ID can take a new entry when empty or when its occupant retires this edge.
    assign id_free   = !id_valid || !stall;
    assign skid_full = skid_valid;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (id_free) begin
            if (skid_valid) begin
                id_valid   <= 1'b1;
                id_pc      <= skid_pc;
                id_instr   <= skid_instr;
                skid_valid <= 1'b0;
            end else if (push) begin
                id_valid <= 1'b1;
                id_pc    <= push_pc;
                id_instr <= push_instr;
            end else begin
                id_valid <= 1'b0;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: payload flops carry no reset; skid_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (push && !id_free && !flush) begin
            skid_pc    <= push_pc;
            skid_instr <= push_instr;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem
// requests, and handles decode stall and branch/jump redirect with kill.
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_stage_if.master        imem,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [31:0]                id_instr,
    output logic [6:0]                 id_opcode,
    output logic [2:0]                 id_funct3,
    output logic [6:0]                 id_funct7,
    output logic                       misalign_err
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] req_pc, req_pc_nxt;
    logic            kill, kill_nxt;
    logic            req;
    logic            fetch_go;
    logic            resp_push;
    logic            skid_full;

    assign fetch_go = req && imem.imem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            req_pc       <= '0;
            misalign_err <= 1'b0;
            // A request granted before reset still owes a response; remember to drop it.
            kill         <= (kill || state == S_WAIT) && !imem.imem_rvalid;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req_pc <= req_pc_nxt;
            kill   <= kill_nxt;
            if (redirect && redirect_pc[1:0] != 2'b00)
                misalign_err <= 1'b1;
        end
    end

    // NOTE: defaults first so no path through the block infers a latch.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        req_pc_nxt = req_pc;
        kill_nxt   = kill;
        unique case (state)
            S_REQ: begin
                if (kill && imem.imem_rvalid)
                    kill_nxt = 1'b0;
                if (fetch_go) begin
                    state_nxt  = S_WAIT;
                    req_pc_nxt = pc;
                    pc_nxt     = pc + XLEN'(4);
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_nxt = S_REQ;
                    kill_nxt  = 1'b0;
                end
            end
        endcase
        if (redirect) begin
            pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
            if ((state == S_WAIT && !imem.imem_rvalid) || (state == S_REQ && fetch_go))
                kill_nxt = 1'b1;
        end
    end

    // Requests pause while a stale pre-reset response is still owed.
    always_comb begin
        req       = 1'b0;
        resp_push = 1'b0;
        unique case (state)
            S_REQ:  req       = !rst && !skid_full && !kill;
            S_WAIT: resp_push = imem.imem_rvalid && !kill && !redirect;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    if_id_skid_buffer #(.XLEN(XLEN)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (resp_push),
        .push_pc    (req_pc),
        .push_instr (imem.imem_rdata),
        .stall      (stall),
        .flush      (redirect),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .skid_full  (skid_full)
    );

    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: the bench plays instruction
// memory and pushes each expected IF/ID entry to a scoreboard queue.
module tb_instr_fetch_stage;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        misalign_err;

    int compared   = 0;
    int mismatched = 0;
    fetch_t sb[$];

    instr_fetch_stage_if #(.XLEN(32)) mem ();

    instr_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (mem),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_funct7    (id_funct7),
        .misalign_err (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Waits (bounded) for a request at addr, grants it, returns data next cycle.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (mem.imem_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        compared++;
        if (mem.imem_req !== 1'b1) begin
            mismatched++;
            $display("FAIL serve_req_timeout: imem_req=%b after %0d cycles, expected 1", mem.imem_req, n);
            return;
        end
        compared++;
        if (mem.imem_addr !== addr) begin
            mismatched++;
            $display("FAIL serve_addr: got %h, expected %h", mem.imem_addr, addr);
        end
        mem.imem_gnt = 1'b1;
        step();
        mem.imem_gnt    = 1'b0;
        mem.imem_rvalid = 1'b1;
        mem.imem_rdata  = data;
        sb.push_back('{pc: addr, instr: data});
        step();
        mem.imem_rvalid = 1'b0;
    endtask

    // Waits (bounded) for id_valid, then compares IF/ID against the scoreboard head.
    task automatic expect_id(input string tag);
        fetch_t e;
        int n = 0;
        while (id_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_scoreboard_empty: id_pc=%h, no expected entry", tag, id_pc);
            return;
        end
        e = sb.pop_front();
        compared++;
        if (id_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_valid: got %b, expected 1 (entry pc %h)", tag, id_valid, e.pc);
            return;
        end
        cmp({tag, "_pc"}, id_pc, e.pc);
        cmp({tag, "_instr"}, id_instr, e.instr);
        cmp({tag, "_fields"}, {15'd0, id_funct7, id_funct3, id_opcode},
            {15'd0, e.instr[31:25], e.instr[14:12], e.instr[6:0]});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        cmp("rst_imem_req", {31'd0, mem.imem_req}, 32'd0);
        cmp("rst_id_valid", {31'd0, id_valid}, 32'd0);
        cmp("rst_id_pc", id_pc, 32'd0);
        cmp("rst_id_instr", id_instr, NOP_INSTR);
        cmp("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;
        #1;
        cmp("rst_release_req", {31'd0, mem.imem_req}, 32'd1);
        cmp("rst_release_addr", mem.imem_addr, 32'h0);
    endtask

    task automatic test_basic_fetch();
        serve(32'h0, 32'h0050_0093);
        // Zero-wait memory: id_valid must be up right after the second edge.
        cmp("latency_id_valid", {31'd0, id_valid}, 32'd1);
        cmp("first_opcode", {25'd0, id_opcode}, {25'd0, OPC_I});
        cmp("first_funct3", {29'd0, id_funct3}, 32'd0);
        expect_id("first");
        serve(32'h4, 32'h00A0_0113);
        expect_id("second");
    endtask

    task automatic test_stall();
        serve(32'h8, 32'h0030_8193);
        stall = 1'b1;
        expect_id("stall_head");
        serve(32'hC, 32'h4020_8233);
        for (int i = 0; i < 6; i++) begin
            step();
            cmp("stall_req_blocked", {31'd0, mem.imem_req}, 32'd0);
            cmp("stall_id_pc_held", id_pc, 32'h8);
        end
        stall = 1'b0;
        step();
        expect_id("stall_skid");
        cmp("stall_resume_req", {31'd0, mem.imem_req}, 32'd1);
        serve(32'h10, 32'h0000_2283);
        expect_id("stall_resume");
    endtask

    task automatic test_redirect_wait();
        serve(32'h14, 32'h0000_0000);
        // Not yet: grant and redirect are done by hand below, so undo the push.
        void'(sb.pop_back());
        stall = 1'b0;
        step();
    endtask

    task automatic test_redirect_in_wait();
        int n = 0;
        while (mem.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        cmp("redir_wait_addr", mem.imem_addr, 32'h14);
        mem.imem_gnt = 1'b1;
        step();
        mem.imem_gnt = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 32'h100;
        step();
        redirect = 1'b0;
        cmp("redir_wait_req_low", {31'd0, mem.imem_req}, 32'd0);
        step();
        step();
        mem.imem_rvalid = 1'b1;
        mem.imem_rdata  = 32'hDEAD_BEEF;
        step();
        mem.imem_rvalid = 1'b0;
        cmp("redir_wait_dropped", {31'd0, id_valid}, 32'd0);
        serve(32'h100, 32'h0010_0513);
        expect_id("redir_wait_target");
    endtask

    task automatic test_redirect_same_cycle();
        mem.imem_gnt = 1'b1;
        step();
        mem.imem_gnt    = 1'b0;
        mem.imem_rvalid = 1'b1;
        mem.imem_rdata  = 32'hCAFE_F00D;
        redirect        = 1'b1;
        redirect_pc     = 32'h200;
        step();
        mem.imem_rvalid = 1'b0;
        redirect        = 1'b0;
        cmp("redir_same_dropped", {31'd0, id_valid}, 32'd0);
        cmp("redir_same_req", {31'd0, mem.imem_req}, 32'd1);
        serve(32'h200, 32'h0020_0593);
        expect_id("redir_same_target");
    endtask

    task automatic test_redirect_on_grant();
        mem.imem_gnt = 1'b1;
        redirect     = 1'b1;
        redirect_pc  = 32'h300;
        step();
        mem.imem_gnt = 1'b0;
        redirect     = 1'b0;
        cmp("redir_gnt_wait", {31'd0, mem.imem_req}, 32'd0);
        mem.imem_rvalid = 1'b1;
        mem.imem_rdata  = 32'h1234_5678;
        step();
        mem.imem_rvalid = 1'b0;
        cmp("redir_gnt_dropped", {31'd0, id_valid}, 32'd0);
        serve(32'h300, 32'h0030_0613);
        expect_id("redir_gnt_target");
    endtask

    task automatic test_misalign();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        cmp("misalign_set", {31'd0, misalign_err}, 32'd1);
        cmp("misalign_addr", mem.imem_addr, 32'h100);
        step();
        step();
        cmp("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        serve(32'h100, 32'h0040_0693);
        expect_id("misalign_fetch");
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        serve(32'hFFFF_FFFC, 32'h0050_0713);
        expect_id("wrap_top");
        serve(32'h0, 32'h0060_0793);
        expect_id("wrap_zero");
    endtask

    task automatic test_reset_in_wait();
        mem.imem_gnt = 1'b1;
        step();
        mem.imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        cmp("rstw_req", {31'd0, mem.imem_req}, 32'd0);
        cmp("rstw_id_valid", {31'd0, id_valid}, 32'd0);
        cmp("rstw_misalign", {31'd0, misalign_err}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        mem.imem_rvalid = 1'b1;
        mem.imem_rdata  = 32'hBAAD_F00D;
        step();
        mem.imem_rvalid = 1'b0;
        cmp("rstw_late_ignored", {31'd0, id_valid}, 32'd0);
        serve(32'h0, 32'h0070_0813);
        expect_id("rstw_first");
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        mem.imem_gnt    = 1'b0;
        mem.imem_rvalid = 1'b0;
        mem.imem_rdata  = 32'h0;

        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_in_wait();
        test_redirect_same_cycle();
        test_redirect_on_grant();
        test_misalign();
        test_wrap();
        test_reset_in_wait();

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
